mux_rr_nx1: RTL and testbench

Parametrised N-to-1 registered multiplexer with per-channel valid/ready handshaking. It is the next generation of the team's fixed 6-input 32-bit select mux. It adds configurable width and channel count, a round-robin arbitration mode, and a registered output stage with backpressure. It sits between several datapath producers and a single consumer, for example result buses feeding a writeback port.

---
 rtl/mux_rr_nx1.sv | 92 +++++++++
 tb/tb_mux_rr_nx1.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mux_rr_nx1.sv
// N-to-1 registered mux with explicit-select or round-robin grant; 1-cycle latency.
// Output register holds under backpressure (out_valid & !out_ready), and all in_ready bits drop.
module mux_rr_nx1 #(
  parameter int N     = 6,
  parameter int WIDTH = 32,
  parameter int SELW  = $clog2(N+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_ch,
  output logic               sel_err
);

  localparam logic [SELW-1:0] NSEL = SELW'(N);
  localparam logic [SELW-1:0] LAST = SELW'(N-1);

  logic [SELW-1:0]  ptr;
  logic [N-1:0]     grant;
  logic             found;
  logic [SELW-1:0]  gidx;
  logic [WIDTH-1:0] gdata;
  logic             load_ok;
  logic             xfer;
  logic             sel_bad;

  // Round-robin scan: first pass covers ptr..N-1, second pass wraps to 0..ptr-1.
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (!mode) begin
      for (int i = 0; i < N; i++) grant[i] = (sel == SELW'(i+1));
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!found && in_valid[i] && (SELW'(i) >= ptr)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!found && in_valid[i] && (SELW'(i) < ptr)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gidx  = '0;
    gdata = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        gidx  = SELW'(i);
        gdata = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign load_ok  = !out_valid | out_ready;
  assign in_ready = grant & {N{load_ok}};
  assign xfer     = |(in_valid & in_ready);
  assign sel_bad  = !mode && ((sel == '0) || (sel > NSEL)) && (|in_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
      sel_err   <= 1'b0;
    end else begin
      sel_err <= sel_bad;
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= gdata;
        out_ch    <= gidx + 1'b1;
        if (mode) ptr <= (gidx == LAST) ? '0 : gidx + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Directed-vector bench for mux_rr_nx1 with a queue scoreboard popped by an output monitor.
module tb_mux_rr_nx1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [2:0]  sel;
  logic [191:0] in_data;
  logic [5:0]  in_valid;
  logic [5:0]  in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_ch;
  logic        sel_err;

  int checks = 0;
  int failures = 0;
  logic [34:0] sb[$];

  mux_rr_nx1 dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one-hot invariant each cycle, and pop/compare on each output handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("in_ready_onehot0", {31'd0, $onehot0(in_ready)}, 32'd1);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'(out_ch), 32'd0);
        end else begin
          logic [34:0] e;
          e = sb.pop_front();
          chk("out_data", out_data, e[34:3]);
          chk("out_ch", 32'(out_ch), 32'(e[2:0]));
        end
      end
    end
  end

  // ech: expected 1-based channel transferred this cycle (0 = none); eerr < 0 skips sel_err.
  task automatic vec(input logic m, input logic [2:0] s, input logic [5:0] v, input logic ordy,
                     input logic [5:0] er, input int ech, input int eerr);
    mode = m; sel = s; in_valid = v; out_ready = ordy;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(er));
    if (eerr >= 0) chk("sel_err", 32'(sel_err), 32'(eerr));
    if (ech != 0) sb.push_back({32'(ech) * 32'h11111111, 3'(ech)});
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 6; i++) in_data[i*32 +: 32] = 32'(i+1) * 32'h11111111;
    rst_n = 1'b0; mode = 1'b0; sel = 3'd0; in_valid = 6'd0; out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Explicit select of channel 3
    vec(1'b0, 3'd3, 6'h3F, 1'b1, 6'b000100, 3, 0);
    // Out-of-range selects hold the output and raise sel_err a cycle later
    vec(1'b0, 3'd0, 6'b000001, 1'b1, 6'b000000, 0, 0);
    chk("hold_valid_sel0", 32'(out_valid), 32'd0);
    chk("hold_data_sel0", out_data, 32'h33333333);
    vec(1'b0, 3'd7, 6'b000001, 1'b1, 6'b000000, 0, 1);
    chk("hold_data_sel7", out_data, 32'h33333333);
    chk("hold_ch_sel7", 32'(out_ch), 32'd3);
    vec(1'b0, 3'd1, 6'b000000, 1'b1, 6'b000001, 0, 1);
    vec(1'b0, 3'd1, 6'b000000, 1'b1, 6'b000001, 0, 0);

    // Round-robin across all six channels with wrap
    vec(1'b1, 3'd0, 6'h3F, 1'b1, 6'b000001, 1, 0);
    vec(1'b1, 3'd0, 6'h3F, 1'b1, 6'b000010, 2, -1);
    vec(1'b1, 3'd0, 6'h3F, 1'b1, 6'b000100, 3, -1);
    vec(1'b1, 3'd0, 6'h3F, 1'b1, 6'b001000, 4, -1);
    vec(1'b1, 3'd0, 6'h3F, 1'b1, 6'b010000, 5, -1);
    vec(1'b1, 3'd0, 6'h3F, 1'b1, 6'b100000, 6, -1);
    vec(1'b1, 3'd0, 6'h3F, 1'b1, 6'b000001, 1, -1);
    vec(1'b1, 3'd0, 6'h3F, 1'b1, 6'b000010, 2, -1);

    // Idle channels skipped
    vec(1'b1, 3'd0, 6'b100100, 1'b1, 6'b000100, 3, -1);
    vec(1'b1, 3'd0, 6'b100100, 1'b1, 6'b100000, 6, -1);
    vec(1'b1, 3'd0, 6'b100100, 1'b1, 6'b000100, 3, -1);
    vec(1'b1, 3'd0, 6'b100100, 1'b1, 6'b100000, 6, -1);

    // Backpressure: three stalled cycles, then pop and push on the same edge
    vec(1'b1, 3'd0, 6'h3F, 1'b1, 6'b000001, 1, -1);
    for (int k = 0; k < 3; k++) begin
      vec(1'b1, 3'd0, 6'h3F, 1'b0, 6'b000000, 0, -1);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", out_data, 32'h11111111);
      chk("bp_ch", 32'(out_ch), 32'd1);
    end
    vec(1'b1, 3'd0, 6'h3F, 1'b1, 6'b000010, 2, -1);
    chk("no_bubble_valid", 32'(out_valid), 32'd1);
    vec(1'b1, 3'd0, 6'b000000, 1'b1, 6'b000000, 0, -1);

    // Reset while a word sits in the output register
    vec(1'b1, 3'd0, 6'h3F, 1'b0, 6'b000100, 0, -1);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_ch", 32'(out_ch), 32'd3);
    rst_n = 1'b0; in_valid = 6'd0;
    #1;
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
    chk("rst2_out_data", out_data, 32'd0);
    chk("rst2_out_ch", 32'(out_ch), 32'd0);
    chk("rst2_sel_err", 32'(sel_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vec(1'b1, 3'd0, 6'b011000, 1'b1, 6'b001000, 4, -1);
    vec(1'b1, 3'd0, 6'b000000, 1'b1, 6'b000000, 0, -1);
    vec(1'b1, 3'd0, 6'b000000, 1'b1, 6'b000000, 0, -1);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
